// File: rtl/frame_feeder.sv
// Ring-buffered sample front end for the FFT core: collects PCM samples, streams
// one zero-padded NFFT frame per window, pulses start, then hops after done.
module frame_feeder #(
   parameter int NFFT        = 512,
   parameter int NFFT_LOG2   = $clog2(NFFT),
   parameter int INPUT_WIDTH = 16,
   parameter int FRAME_LEN   = 400,
   parameter int HOP         = 160
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sample_valid_i,
   input  logic [INPUT_WIDTH-1:0] sample_i,
   output logic                   sample_ready_o,
   input  logic                   flush_i,
   output logic                   frame_valid_o,
   output logic [NFFT_LOG2-1:0]   frame_ptr_o,
   output logic [INPUT_WIDTH-1:0] frame_sample_o,
   output logic                   fft_start_o,
   input  logic                   fft_done_i,
   output logic [15:0]            frame_count_o,
   output logic [2:0]             fsm_state_o
);

   // Handshakes: a sample moves on a cycle where sample_valid_i && sample_ready_o;
   // the source holds sample_i stable while valid is high and ready is low.

   localparam int                   CW          = NFFT_LOG2 + 1;
   localparam logic [CW-1:0]        NFFT_C      = CW'(NFFT);
   localparam logic [CW-1:0]        FRAME_LEN_C = CW'(FRAME_LEN);
   localparam logic [CW-1:0]        HOP_C       = CW'(HOP);
   localparam logic [NFFT_LOG2-1:0] HOP_P       = NFFT_LOG2'(HOP);
   localparam logic [NFFT_LOG2-1:0] LAST_IDX    = NFFT_LOG2'(NFFT - 1);

   // Debug encoding on fsm_state_o: IDLE=0 STREAM=1 START=2 WAIT_DONE=3 ADVANCE=4
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_STREAM    = 3'd1,
      S_START     = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_ADVANCE   = 3'd4
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [NFFT_LOG2-1:0]   wr_ptr;
   logic [NFFT_LOG2-1:0]   base_ptr;
   logic [NFFT_LOG2-1:0]   rd_idx;
   logic [NFFT_LOG2-1:0]   rd_addr;
   logic [CW-1:0]          count;
   logic [INPUT_WIDTH-1:0] ring [NFFT];

   logic streaming;
   logic issue_start;
   logic advancing;
   logic flushing;
   logic in_window;
   logic wr_en;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (!flush_i && count >= FRAME_LEN_C) state_nxt = S_STREAM;
         S_STREAM:    if (rd_idx == LAST_IDX) state_nxt = S_START;
         S_START:     state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: if (fft_done_i) state_nxt = S_ADVANCE;
         S_ADVANCE:   state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      streaming   = 1'b0;
      issue_start = 1'b0;
      advancing   = 1'b0;
      flushing    = 1'b0;
      case (state)
         S_IDLE:    flushing    = flush_i;
         S_STREAM:  streaming   = 1'b1;
         S_START:   issue_start = 1'b1;
         S_ADVANCE: advancing   = 1'b1;
         default:   ;
      endcase
   end

   assign fsm_state_o    = state;
   assign sample_ready_o = (count < NFFT_C);
   // A flush in IDLE also swallows any sample handed over in the same cycle.
   assign wr_en          = sample_valid_i && sample_ready_o && !flushing;
   assign in_window      = ({1'b0, rd_idx} < FRAME_LEN_C);
   assign rd_addr        = base_ptr + rd_idx;

   always_ff @(posedge clk) begin
      if (rst || flushing) begin
         wr_ptr   <= '0;
         base_ptr <= '0;
         count    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + NFFT_LOG2'(1);
         if (advancing) base_ptr <= base_ptr + HOP_P;
         count <= count + CW'(wr_en) - (advancing ? HOP_C : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rd_idx <= '0;
      else     rd_idx <= streaming ? rd_idx + NFFT_LOG2'(1) : '0;
   end

   always_ff @(posedge clk) begin
      if (wr_en) ring[wr_ptr] <= sample_i;
   end

   // Ring read and output register are the same stage, so valid trails STREAM by one.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_valid_o  <= 1'b0;
         frame_ptr_o    <= '0;
         frame_sample_o <= '0;
         fft_start_o    <= 1'b0;
         frame_count_o  <= '0;
      end else begin
         frame_valid_o  <= streaming;
         frame_ptr_o    <= streaming ? rd_idx : '0;
         frame_sample_o <= (streaming && in_window) ? ring[rd_addr] : '0;
         fft_start_o    <= issue_start;
         if (issue_start) frame_count_o <= frame_count_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_frame_feeder.sv
// Bench for frame_feeder: a sample-history queue models the ring; each frame is
// predicted as the oldest FRAME_LEN held samples followed by zero padding.
module tb_frame_feeder;
   localparam int NFFT      = 512;
   localparam int NFFT_LOG2 = 9;
   localparam int W         = 16;
   localparam int FRAME_LEN = 400;
   localparam int HOP       = 160;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 sample_valid_i;
   logic [W-1:0]         sample_i;
   logic                 sample_ready_o;
   logic                 flush_i = 1'b0;
   logic                 frame_valid_o;
   logic [NFFT_LOG2-1:0] frame_ptr_o;
   logic [W-1:0]         frame_sample_o;
   logic                 fft_start_o;
   logic                 fft_done_i;
   logic [15:0]          frame_count_o;
   logic [2:0]           fsm_state_o;

   frame_feeder #(
      .NFFT(NFFT), .NFFT_LOG2(NFFT_LOG2), .INPUT_WIDTH(W),
      .FRAME_LEN(FRAME_LEN), .HOP(HOP)
   ) dut (
      .clk(clk), .rst(rst),
      .sample_valid_i(sample_valid_i), .sample_i(sample_i), .sample_ready_o(sample_ready_o),
      .flush_i(flush_i),
      .frame_valid_o(frame_valid_o), .frame_ptr_o(frame_ptr_o), .frame_sample_o(frame_sample_o),
      .fft_start_o(fft_start_o), .fft_done_i(fft_done_i),
      .frame_count_o(frame_count_o), .fsm_state_o(fsm_state_o)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // reference model state and scoreboard
   logic [W-1:0] acc_q[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] first_q[$];
   logic [W-1:0] last_q[$];
   logic [W-1:0] special_q[$];
   logic [W-1:0] exp_v;
   logic [W-1:0] seq_val     = '0;
   logic [W-1:0] dropped_val = '0;
   int  n_compared = 0, n_mismatched = 0;
   int  frames_done = 0, frame_idx = 0, done_wait = 0;
   int  gap_pct = 0, feed_left = -1, last_rise_size = -1;
   int  sz_h0 = 0, sz_h1 = 0, sz_h2 = 0;
   bit  in_frame = 0, frame_busy = 0, await_done = 0, hold_done = 0, stray_done = 0;
   bit  took = 0, ready_prev = 1, rand_data = 0, rand_done = 0;
   bit  seen_neg = 0, seen_pos = 0, dropped_seen = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // driver: sample source, holds each sample until the handshake completes
   initial begin : feeder
      sample_valid_i = 1'b0;
      sample_i       = '0;
      forever begin
         @(posedge clk); #1;
         if (!sample_valid_i || took) begin
            sample_valid_i = 1'b0;
            if (feed_left != 0 && $urandom_range(0, 99) >= gap_pct) begin
               sample_valid_i = 1'b1;
               if (special_q.size() > 0) sample_i = special_q.pop_front();
               else if (rand_data) sample_i = W'($urandom);
               else begin
                  seq_val  = seq_val + 1'b1;
                  sample_i = seq_val;
               end
               if (feed_left > 0) feed_left--;
            end
         end
      end
   end

   // driver: FFT done responder
   initial begin : responder
      fft_done_i = 1'b0;
      forever begin
         @(posedge clk); #1;
         fft_done_i = 1'b0;
         if (stray_done) begin
            fft_done_i = 1'b1;
            stray_done = 0;
         end else if (await_done && !hold_done && !rst) begin
            if (done_wait == 0) fft_done_i = 1'b1;
            else done_wait--;
         end
      end
   end

   // monitor + model, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         acc_q.delete(); exp_q.delete();
         in_frame = 0; frame_busy = 0; await_done = 0; frames_done = 0;
         took = 0; ready_prev = 1; sz_h0 = 0; sz_h1 = 0; sz_h2 = 0;
      end else begin
         took = sample_valid_i && sample_ready_o;
         if (sample_ready_o && !ready_prev) last_rise_size = acc_q.size();
         ready_prev = sample_ready_o;
         if (flush_i && !frame_busy) begin
            acc_q.delete();
            if (took) begin
               dropped_val  = sample_i;
               dropped_seen = 1;
            end
         end else if (took) acc_q.push_back(sample_i);
         if (fft_done_i && await_done) begin
            await_done = 0;
            frame_busy = 0;
            for (int i = 0; i < HOP; i++) if (acc_q.size() > 0) void'(acc_q.pop_front());
         end
         if (frame_valid_o) begin
            if (!in_frame) begin
               in_frame   = 1;
               frame_busy = 1;
               frame_idx  = 0;
               exp_q.delete();
               // the start decision was taken on the count held two cycles earlier
               check_eq("frame_has_window", 32'(sz_h2 >= FRAME_LEN), 1);
               for (int i = 0; i < NFFT; i++)
                  exp_q.push_back((i < FRAME_LEN && i < acc_q.size()) ? acc_q[i] : '0);
               first_q.push_back(frame_sample_o);
            end
            if (frame_idx == FRAME_LEN - 1) last_q.push_back(frame_sample_o);
            if (frame_sample_o == 16'h8000) seen_neg = 1;
            if (frame_sample_o == 16'h7FFF) seen_pos = 1;
            exp_v = '1;
            if (exp_q.size() > 0) exp_v = exp_q.pop_front();
            check_eq("frame_ptr", 32'(frame_ptr_o), frame_idx);
            check_eq("frame_data", 32'(frame_sample_o), 32'(exp_v));
            check_eq("start_low_in_frame", 32'(fft_start_o), 0);
            frame_idx++;
         end else if (in_frame) begin
            in_frame = 0;
            check_eq("frame_length", frame_idx, NFFT);
            check_eq("start_pulse", 32'(fft_start_o), 1);
            frames_done++;
            check_eq("frame_count", 32'(frame_count_o), frames_done);
            await_done = 1;
            done_wait  = rand_done ? $urandom_range(0, 60) : 50;
         end else begin
            check_eq("no_stray_start", 32'(fft_start_o), 0);
         end
         sz_h2 = sz_h1;
         sz_h1 = sz_h0;
         sz_h0 = acc_q.size();
      end
   end

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int k = 0;
      while (frames_done < n && k < budget) begin
         tick();
         k++;
      end
      check_eq("frames_reached", frames_done, n);
   endtask

   task automatic wait_in_frame(input int budget);
      int k = 0;
      while (!in_frame && k < budget) begin
         tick();
         k++;
      end
      check_eq("frame_seen", 32'(in_frame), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, 32'(sample_ready_o), 1);
      check_eq({tag, "_valid"}, 32'(frame_valid_o), 0);
      check_eq({tag, "_ptr"}, 32'(frame_ptr_o), 0);
      check_eq({tag, "_sample"}, 32'(frame_sample_o), 0);
      check_eq({tag, "_start"}, 32'(fft_start_o), 0);
      check_eq({tag, "_count"}, 32'(frame_count_o), 0);
      check_eq({tag, "_state_idle"}, 32'(fsm_state_o), 0);
   endtask

   initial begin : main
      int k;
      int base;
      int stable;
      // reset with the source already presenting data
      rst = 1'b1;
      tick(); tick();
      check_reset_outputs("rst");
      @(posedge clk); #1;
      rst = 1'b0;

      // first frame from samples 1..400
      wait_frames(1, 3000);
      check_eq("f1_first", 32'(first_q.size() > 0 ? first_q[0] : '1), 1);
      check_eq("f1_last_in_window", 32'(last_q.size() > 0 ? last_q[0] : '1), 400);

      // second frame after the hop
      wait_frames(2, 3000);
      check_eq("f2_first", 32'(first_q.size() > 1 ? first_q[1] : '1), 161);
      check_eq("f2_last_in_window", 32'(last_q.size() > 1 ? last_q[1] : '1), 560);

      // backpressure: withhold done until the ring fills
      hold_done = 1;
      k = 0;
      while (sample_ready_o && k < 2000) begin
         tick();
         k++;
      end
      check_eq("full_at_nfft", acc_q.size(), NFFT);
      repeat (20) tick();
      check_eq("ready_held_low", 32'(sample_ready_o), 0);
      check_eq("no_advance_while_held", frames_done, 2);
      hold_done = 0;
      wait_frames(3, 3000);
      check_eq("ready_rise_count", last_rise_size, NFFT - HOP);
      check_eq("f3_first", 32'(first_q.size() > 2 ? first_q[2] : '1), 321);

      // extreme values, plus done and flush during STREAM
      special_q.push_back(16'h8000);
      special_q.push_back(16'h7FFF);
      base = frames_done;
      wait_in_frame(3000);
      repeat (20) tick();
      @(posedge clk); #1;
      flush_i    = 1'b1;
      stray_done = 1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      wait_frames(base + 4, 12000);
      check_eq("seen_8000", 32'(seen_neg), 1);
      check_eq("seen_7fff", 32'(seen_pos), 1);

      // drain to a quiet IDLE, then flush
      feed_left = 0;
      stable = 0;
      k = 0;
      while (stable < 5 && k < 6000) begin
         tick();
         k++;
         if (!in_frame && !frame_busy && !await_done && acc_q.size() < FRAME_LEN && !sample_valid_i)
            stable++;
         else
            stable = 0;
      end
      check_eq("idle_reached", 32'(stable >= 5), 1);
      @(posedge clk); #1;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      base = frames_done;
      feed_left = 300;
      k = 0;
      while ((feed_left != 0 || sample_valid_i) && k < 1000) begin
         tick();
         k++;
      end
      repeat (10) tick();
      check_eq("no_frame_below_window", frames_done, base);
      check_eq("ready_after_300", 32'(sample_ready_o), 1);
      // second flush while a sample is being handed over: that sample is dropped
      feed_left = -1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      wait_frames(base + 1, 3000);
      check_eq("flush_dropped_accept", 32'(dropped_seen), 1);
      check_eq("post_flush_first", 32'(first_q.size() > 0 ? first_q[$] : '1), 32'(W'(dropped_val + 1'b1)));

      // reset in the middle of a frame
      wait_in_frame(3000);
      repeat (30) tick();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      tick();
      check_reset_outputs("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      wait_frames(1, 3000);

      // randomized data, gaps and done latency
      rand_data = 1;
      rand_done = 1;
      gap_pct   = 30;
      base = frames_done;
      wait_frames(base + 4, 16000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/frame_feeder.md
# frame_feeder

Streaming front end that sits between the audio sample source and the FFT core in the MFCC pipeline. It stores incoming PCM samples in an NFFT-deep ring buffer and, once a full analysis window is available and the FFT is idle, writes one frame into the FFT input buffer. Samples beyond FRAME_LEN are zero-padded to NFFT. It then pulses the FFT start, waits for the FFT done pulse, and advances the window by HOP samples. It is the writer side of the FFT core's sample-load / start / done handshake.

## Interface
- NFFT, 512, FFT size; power of two; also the ring depth
- NFFT_LOG2, $clog2(NFFT), pointer width
- INPUT_WIDTH, 16, signed PCM sample width
- FRAME_LEN, 400, samples per analysis window; 1 ≤ FRAME_LEN ≤ NFFT
- HOP, 160, window advance; 1 ≤ HOP ≤ FRAME_LEN
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- sample_valid_i  in  1  input sample present
- sample_i  in  INPUT_WIDTH  signed PCM sample
- sample_ready_o  out  1  sample accepted when valid & ready
- flush_i  in  1  discard all buffered samples (honoured in IDLE only)
- frame_valid_o  out  1  drives FFT in_valid
- frame_ptr_o  out  NFFT_LOG2  natural-order index; the FFT core bit-reverses internally
- frame_sample_o  out  INPUT_WIDTH  drives FFT real_in
- fft_start_o  out  1  one-cycle pulse; drives FFT start_i
- fft_done_i  in  1  FFT done pulse
- frame_count_o  out  16  frames issued, wraps

## Operation
- State: wr_ptr, base_ptr (NFFT_LOG2 bits, wrap mod NFFT), count (NFFT_LOG2+1 bits, 0..NFFT) = samples held from base_ptr onward.
- Accept: sample_ready_o = (count < NFFT), in every state.
  - On accept: ring[wr_ptr] ← sample_i, wr_ptr+1, count+1.
- FSM:
  - IDLE:
    - If flush_i: count, wr_ptr and base_ptr ← 0; any accept in the same cycle is dropped; stay in IDLE.
    - Else if count ≥ FRAME_LEN → STREAM, rd_idx ← 0.
  - STREAM: issue read of ring[base_ptr+rd_idx] for rd_idx 0..NFFT-1, one per cycle.
    - rd_idx ≥ FRAME_LEN is issued as a zero sample; no ring read.
    - After rd_idx = NFFT-1 → START.
  - START: wait for the last registered sample to drain, pulse fft_start_o, frame_count_o+1 → WAIT_DONE.
  - WAIT_DONE: on fft_done_i → ADVANCE.
  - ADVANCE: base_ptr += HOP, count −= HOP, → IDLE.
    - An accept in the same cycle gives net count − HOP + 1.
- fft_done_i outside WAIT_DONE is ignored. flush_i outside IDLE is ignored.
- base_ptr and the ring contents at base_ptr..base_ptr+FRAME_LEN-1 are never overwritten while a frame is outstanding (guaranteed by count ≤ NFFT).
- Samples pass through unmodified: no scaling, no sign change.

## Timing
- Reset values: sample_ready_o 1 (count = 0 after reset), frame_valid_o 0, frame_ptr_o 0, frame_sample_o 0, fft_start_o 0, frame_count_o 0; FSM in IDLE, all pointers 0.
- Output registers: frame_valid_o, frame_ptr_o, frame_sample_o are registered; the ring read is synchronous.
- STREAM entry at cycle T: frame_valid_o is high for exactly NFFT consecutive cycles, T+1..T+NFFT, with frame_ptr_o = 0..NFFT-1 in order.
- fft_start_o is high for one cycle only, at T+NFFT+1, and is low during every frame_valid_o cycle.
- The earliest next STREAM entry is 2 cycles after the fft_done_i cycle (ADVANCE, then IDLE evaluating count).
- IDLE→STREAM decision uses the registered count; a sample accepted in that cycle is counted the next cycle.
- Reset asserted mid-frame: all outputs return to reset values on the next edge. No fft_start_o is issued for the partial frame. The FFT buffer contents are then undefined but unused.

## Test plan
- Reset/idle: assert rst for 2 cycles with sample_valid_i held high → all outputs at reset values; after release, ready = 1 and no frame_valid_o until 400 samples are accepted.
- First frame (defaults): push samples 1..400 back-to-back.
  - Expect 512 valid cycles: ptr 0..399 carry 1..400, ptr 400..511 carry 0.
  - Then exactly one fft_start_o pulse, and frame_count_o = 1.
- Hop: keep streaming 401.. and return fft_done_i 50 cycles after start.
  - Second frame begins only after done and count ≥ 400.
  - ptr 0 = 161, ptr 399 = 560; frame_count_o = 2.
- Backpressure: hold fft_done_i low while pushing continuously.
  - sample_ready_o drops after 512 accepts.
  - After fft_done_i, ready reasserts at count = 352.
  - Third frame data is contiguous (ptr 0 = 321), with no lost or duplicated samples.
- Edge values and ignored controls: samples 0x8000 and 0x7FFF appear unchanged on frame_sample_o. fft_done_i pulsed during STREAM is ignored (no advance). flush_i during STREAM is ignored.
- Flush in IDLE: push 300 samples, pulse flush_i → count 0; the next frame needs 400 fresh samples and starts with the first post-flush sample.
